ex_operand_stage: RTL

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage_if.sv | 60 ++++++
 rtl/ex_operand_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ex_operand_stage_if.sv
// Operand-stage bus: ID-side operands, EX/MEM and MEM/WB bypass taps,
// pipeline control and the registered EX-side outputs.
interface ex_operand_stage_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_LEN = 5
);
  // ID side
  logic                id_valid;
  logic [4:0]          id_fn;
  logic [ADDR_LEN-1:0] id_rs1_addr;
  logic [ADDR_LEN-1:0] id_rs2_addr;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [XLEN-1:0]     id_pc;
  logic [XLEN-1:0]     id_imm;
  logic                id_src1_sel;
  logic                id_src2_sel;
  logic [ADDR_LEN-1:0] id_rd_addr;
  logic                id_rd_we;
  logic                id_ready;
  // Bypass taps
  logic                mem_rd_we;
  logic [ADDR_LEN-1:0] mem_rd_addr;
  logic [XLEN-1:0]     mem_data;
  logic                mem_is_load;
  logic                wb_rd_we;
  logic [ADDR_LEN-1:0] wb_rd_addr;
  logic [XLEN-1:0]     wb_data;
  // Control
  logic                stall;
  logic                flush;
  // EX side
  logic                ex_valid;
  logic [4:0]          ex_fn;
  logic [XLEN-1:0]     ex_src1;
  logic [XLEN-1:0]     ex_src2;
  logic [XLEN-1:0]     ex_store_data;
  logic [ADDR_LEN-1:0] ex_rd_addr;
  logic                ex_rd_we;

  // Pipeline side driving the stage
  modport master (
    output id_valid, id_fn, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_pc, id_imm, id_src1_sel, id_src2_sel, id_rd_addr, id_rd_we,
           mem_rd_we, mem_rd_addr, mem_data, mem_is_load,
           wb_rd_we, wb_rd_addr, wb_data, stall, flush,
    input  id_ready, ex_valid, ex_fn, ex_src1, ex_src2, ex_store_data,
           ex_rd_addr, ex_rd_we
  );

  // The operand stage itself
  modport slave (
    input  id_valid, id_fn, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_pc, id_imm, id_src1_sel, id_src2_sel, id_rd_addr, id_rd_we,
           mem_rd_we, mem_rd_addr, mem_data, mem_is_load,
           wb_rd_we, wb_rd_addr, wb_data, stall, flush,
    output id_ready, ex_valid, ex_fn, ex_src1, ex_src2, ex_store_data,
           ex_rd_addr, ex_rd_we
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID->EX operand stage: resolves rs1/rs2, selects ALU operands and
// registers them into EX, handling stall, flush and data hazards.
// Macro FORWARD_EN: defined -> EX/MEM and MEM/WB bypassing with a
// load-use interlock; undefined -> no bypassing, any pending write to a
// source register interlocks.
module ex_operand_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_LEN = 5
) (
  input logic                clk,
  input logic                rst_n,
  ex_operand_stage_if.slave  bus
);

  localparam logic [4:0] ALU_X = 5'd0;

  logic                w_mem_hit1, w_mem_hit2, w_wb_hit1, w_wb_hit2;
  logic [XLEN-1:0]     w_rs1, w_rs2;
  logic                w_hazard;

  logic                r_ex_valid, w_nxt_valid;
  logic [4:0]          r_ex_fn, w_nxt_fn;
  logic [XLEN-1:0]     r_ex_src1, w_nxt_src1;
  logic [XLEN-1:0]     r_ex_src2, w_nxt_src2;
  logic [XLEN-1:0]     r_ex_store_data, w_nxt_store_data;
  logic [ADDR_LEN-1:0] r_ex_rd_addr, w_nxt_rd_addr;
  logic                r_ex_rd_we, w_nxt_rd_we;

  // x0 never matches: a write to x0 is architecturally discarded
  assign w_mem_hit1 = bus.mem_rd_we && (bus.id_rs1_addr != '0) &&
                      (bus.mem_rd_addr == bus.id_rs1_addr);
  assign w_mem_hit2 = bus.mem_rd_we && (bus.id_rs2_addr != '0) &&
                      (bus.mem_rd_addr == bus.id_rs2_addr);
  assign w_wb_hit1  = bus.wb_rd_we && (bus.id_rs1_addr != '0) &&
                      (bus.wb_rd_addr == bus.id_rs1_addr);
  assign w_wb_hit2  = bus.wb_rd_we && (bus.id_rs2_addr != '0) &&
                      (bus.wb_rd_addr == bus.id_rs2_addr);

`ifdef FORWARD_EN
  // Youngest producer (EX/MEM) wins over MEM/WB
  always_comb begin
    w_rs1 = bus.id_rs1_data;
    w_rs2 = bus.id_rs2_data;
    if (w_mem_hit1)     w_rs1 = bus.mem_data;
    else if (w_wb_hit1) w_rs1 = bus.wb_data;
    if (w_mem_hit2)     w_rs2 = bus.mem_data;
    else if (w_wb_hit2) w_rs2 = bus.wb_data;
  end

  // Load data is not available in EX/MEM yet, so a dependent op must wait
  assign w_hazard = bus.id_valid && bus.mem_is_load && (w_mem_hit1 || w_mem_hit2);
`else
  assign w_rs1 = bus.id_rs1_data;
  assign w_rs2 = bus.id_rs2_data;

  // Without bypassing every in-flight write to a source is a hazard
  assign w_hazard = bus.id_valid &&
                    (w_mem_hit1 || w_mem_hit2 || w_wb_hit1 || w_wb_hit2);

  logic w_unused_bypass;
  assign w_unused_bypass = ^{bus.mem_data, bus.wb_data, bus.mem_is_load};
`endif

  assign bus.id_ready = !bus.stall && !w_hazard && !bus.flush;

  // Next EX contents: flush > stall > bubble (hazard/invalid) > capture
  always_comb begin
    w_nxt_valid      = r_ex_valid;
    w_nxt_fn         = r_ex_fn;
    w_nxt_src1       = r_ex_src1;
    w_nxt_src2       = r_ex_src2;
    w_nxt_store_data = r_ex_store_data;
    w_nxt_rd_addr    = r_ex_rd_addr;
    w_nxt_rd_we      = r_ex_rd_we;
    if (bus.flush || (!bus.stall && (w_hazard || !bus.id_valid))) begin
      w_nxt_valid      = 1'b0;
      w_nxt_fn         = ALU_X;
      w_nxt_src1       = '0;
      w_nxt_src2       = '0;
      w_nxt_store_data = '0;
      w_nxt_rd_addr    = '0;
      w_nxt_rd_we      = 1'b0;
    end else if (!bus.stall) begin
      w_nxt_valid      = 1'b1;
      w_nxt_fn         = bus.id_fn;
      w_nxt_src1       = bus.id_src1_sel ? bus.id_pc  : w_rs1;
      w_nxt_src2       = bus.id_src2_sel ? bus.id_imm : w_rs2;
      w_nxt_store_data = w_rs2;
      w_nxt_rd_addr    = bus.id_rd_addr;
      w_nxt_rd_we      = bus.id_rd_we && (bus.id_rd_addr != '0);
    end
  end

  // EX pipeline register; reset loads the bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_fn         <= ALU_X;
      r_ex_src1       <= '0;
      r_ex_src2       <= '0;
      r_ex_store_data <= '0;
      r_ex_rd_addr    <= '0;
      r_ex_rd_we      <= 1'b0;
    end else begin
      r_ex_valid      <= w_nxt_valid;
      r_ex_fn         <= w_nxt_fn;
      r_ex_src1       <= w_nxt_src1;
      r_ex_src2       <= w_nxt_src2;
      r_ex_store_data <= w_nxt_store_data;
      r_ex_rd_addr    <= w_nxt_rd_addr;
      r_ex_rd_we      <= w_nxt_rd_we;
    end
  end

  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_fn         = r_ex_fn;
  assign bus.ex_src1       = r_ex_src1;
  assign bus.ex_src2       = r_ex_src2;
  assign bus.ex_store_data = r_ex_store_data;
  assign bus.ex_rd_addr    = r_ex_rd_addr;
  assign bus.ex_rd_we      = r_ex_rd_we;

endmodule
